// File: rtl/gun_pkg.sv
// Shared types, limits and helpers for the gun cross-hair stepper.
// Optional feature macro: GUN_MOUSE_EN (mouse accumulation in gun_axis).
package gun_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } gun_axis_state_t;

    localparam int unsigned GUN_POS_W   = 6;
    localparam int unsigned GUN_MIN     = 0;
    localparam int unsigned GUN_MAX     = 63;
    localparam int unsigned GUN_CENTER  = 32;
    localparam int unsigned GUN_CNT_W   = 5;   // holds 0..31 for delay/accel counters
    localparam int unsigned GUN_DELTA_W = 10;  // 9-bit mouse delta, widened so -(-256) fits
    localparam int unsigned GUN_SUM_W   = 12;  // position sum, wide enough never to wrap

    localparam logic signed [GUN_SUM_W-1:0] GUN_SUM_MIN = GUN_SUM_W'(GUN_MIN);
    localparam logic signed [GUN_SUM_W-1:0] GUN_SUM_MAX = GUN_SUM_W'(GUN_MAX);

    // Saturate a signed position sum into the 0..63 cross-hair range.
    function automatic logic [GUN_POS_W-1:0] gun_clamp(input logic signed [GUN_SUM_W-1:0] v);
        if (v < GUN_SUM_MIN) begin
            return GUN_POS_W'(GUN_MIN);
        end else if (v > GUN_SUM_MAX) begin
            return GUN_POS_W'(GUN_MAX);
        end else begin
            return v[GUN_POS_W-1:0];
        end
    endfunction

endpackage

// File: rtl/gun_axis.sv
// One gun axis: press/delay/repeat stepper with acceleration, optional mouse
// accumulator (GUN_MOUSE_EN) and a single clamp on the summed step.
// Ports: clk_sys, reset_n (async, active low), rise (tick edge), neg/pos_in
// (direction buttons), mouse_strobe/delta (GUN_MOUSE_EN only), pos (registered
// 0..63), busy_c (next state is not IDLE; registered by the parent).
module gun_axis
    import gun_pkg::*;
#(
    parameter int unsigned DELAY_TICKS = 8,
    parameter int unsigned ACCEL_TICKS = 16
`ifdef GUN_MOUSE_EN
    ,
    parameter int unsigned MOUSE_SHIFT = 2
`endif
) (
    input  logic                          clk_sys,
    input  logic                          reset_n,
    input  logic                          rise,
    input  logic                          neg,
    input  logic                          pos_in,
`ifdef GUN_MOUSE_EN
    input  logic                          mouse_strobe,
    input  logic signed [GUN_DELTA_W-1:0] delta,
`endif
    output logic [GUN_POS_W-1:0]          pos,
    output logic                          busy_c
);

    localparam logic [GUN_CNT_W-1:0] DLY_LOAD = GUN_CNT_W'(DELAY_TICKS - 1);
    localparam logic [GUN_CNT_W-1:0] ACC_SAT  = GUN_CNT_W'(ACCEL_TICKS);

    gun_axis_state_t        state, state_nxt;
    logic                   dir_neg, dir_neg_nxt;
    logic [GUN_CNT_W-1:0]   dly, dly_nxt;
    logic [GUN_CNT_W-1:0]   acc_cnt, acc_nxt;
    logic [1:0]             joy_mag;
    logic                   d_nz, d_neg, reversal, upd;
    logic signed [GUN_SUM_W-1:0] pos_ext, joy_step, mouse_step, sum;

    // Both or neither button pressed is treated as no direction.
    assign d_nz     = pos_in ^ neg;
    assign d_neg    = neg & ~pos_in;
    assign reversal = (d_neg != dir_neg);

    // State register and counters.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            dir_neg <= 1'b0;
            dly     <= '0;
            acc_cnt <= '0;
        end else begin
            state   <= state_nxt;
            dir_neg <= dir_neg_nxt;
            dly     <= dly_nxt;
            acc_cnt <= acc_nxt;
        end
    end

    // Next-state logic; a reversal restarts as a fresh press in the new direction.
    always_comb begin
        state_nxt   = state;
        dir_neg_nxt = dir_neg;
        dly_nxt     = dly;
        acc_nxt     = acc_cnt;
        if (rise) begin
            case (state)
                IDLE: begin
                    if (d_nz) begin
                        state_nxt   = DELAY;
                        dly_nxt     = DLY_LOAD;
                        dir_neg_nxt = d_neg;
                    end
                end
                DELAY, REPEAT: begin
                    if (!d_nz) begin
                        state_nxt = IDLE;
                    end else if (reversal) begin
                        state_nxt   = DELAY;
                        dly_nxt     = DLY_LOAD;
                        dir_neg_nxt = d_neg;
                    end else if (state == DELAY) begin
                        if (dly == '0) begin
                            state_nxt = REPEAT;
                            acc_nxt   = '0;
                        end else begin
                            dly_nxt = dly - GUN_CNT_W'(1);
                        end
                    end else if (acc_cnt < ACC_SAT) begin
                        acc_nxt = acc_cnt + GUN_CNT_W'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // Output logic: joystick step magnitude for this tick and busy indication.
    always_comb begin
        joy_mag = 2'd0;
        busy_c  = (state_nxt != IDLE);
        if (rise && d_nz) begin
            case (state)
                IDLE:    joy_mag = 2'd1;
                DELAY:   joy_mag = reversal ? 2'd1 : 2'd0;
                REPEAT:  joy_mag = (reversal || (acc_cnt < ACC_SAT)) ? 2'd1 : 2'd2;
                default: joy_mag = 2'd0;
            endcase
        end
    end

    assign joy_step = d_neg ? -GUN_SUM_W'(joy_mag) : GUN_SUM_W'(joy_mag);

`ifdef GUN_MOUSE_EN
    localparam int unsigned MACC_W = 11;

    logic signed [MACC_W-1:0] macc, macc_sum, macc_bias, macc_step, macc_nxt;

    // Divide by 2^MOUSE_SHIFT truncating toward zero; the remainder stays in macc.
    always_comb begin
        macc_sum  = macc + MACC_W'(delta);
        macc_bias = macc_sum[MACC_W-1] ? MACC_W'((1 << MOUSE_SHIFT) - 1) : '0;
        macc_step = (macc_sum + macc_bias) >>> MOUSE_SHIFT;
        macc_nxt  = macc_sum - (macc_step <<< MOUSE_SHIFT);
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            macc <= '0;
        end else if (mouse_strobe) begin
            macc <= macc_nxt;
        end
    end

    assign mouse_step = mouse_strobe ? GUN_SUM_W'(macc_step) : '0;
    assign upd        = rise | mouse_strobe;
`else
    assign mouse_step = '0;
    assign upd        = rise;
`endif

    // Joystick and mouse contributions share one clamp.
    assign pos_ext = GUN_SUM_W'(pos);
    assign sum     = pos_ext + joy_step + mouse_step;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            pos <= GUN_POS_W'(GUN_CENTER);
        end else if (upd) begin
            pos <= gun_clamp(sum);
        end
    end

endmodule

// File: rtl/gun_position.sv
// Gun cross-hair position from joystick (and, with GUN_MOUSE_EN, PS/2 mouse
// deltas), paced by the rising edge of the core's 4 ms tick.
// Ports: clk_sys, reset_n (async, active low), tick, joy_left/right/up/down,
// mouse_strobe/mouse_dx/mouse_dy (GUN_MOUSE_EN only), gun_h/gun_v (registered
// 0..63), moving (registered, either axis active).
module gun_position
    import gun_pkg::*;
#(
    parameter int unsigned DELAY_TICKS = 8,
    parameter int unsigned ACCEL_TICKS = 16,
    parameter int unsigned MOUSE_SHIFT = 2
) (
    input  logic                 clk_sys,
    input  logic                 reset_n,
    input  logic                 tick,
    input  logic                 joy_left,
    input  logic                 joy_right,
    input  logic                 joy_up,
    input  logic                 joy_down,
`ifdef GUN_MOUSE_EN
    input  logic                 mouse_strobe,
    input  logic signed [8:0]    mouse_dx,
    input  logic signed [8:0]    mouse_dy,
`endif
    output logic [GUN_POS_W-1:0] gun_h,
    output logic [GUN_POS_W-1:0] gun_v,
    output logic                 moving
);

    // Elaboration-time parameter range checks.
    if (DELAY_TICKS < 1 || DELAY_TICKS > 31) begin : g_bad_delay
        $error("gun_position: DELAY_TICKS out of range 1..31");
    end
    if (ACCEL_TICKS < 1 || ACCEL_TICKS > 31) begin : g_bad_accel
        $error("gun_position: ACCEL_TICKS out of range 1..31");
    end
    if (MOUSE_SHIFT > 4) begin : g_bad_shift
        $error("gun_position: MOUSE_SHIFT out of range 0..4");
    end

    logic tick_r, rise;
    logic busy_h_c, busy_v_c;

    // Tick rising-edge detector.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            tick_r <= 1'b0;
        end else begin
            tick_r <= tick;
        end
    end

    assign rise = tick & ~tick_r;

`ifdef GUN_MOUSE_EN
    // Screen v grows downward while mouse +dy means up, hence the negation.
    logic signed [GUN_DELTA_W-1:0] delta_h, delta_v;
    assign delta_h = GUN_DELTA_W'(mouse_dx);
    assign delta_v = -GUN_DELTA_W'(mouse_dy);
`endif

    gun_axis #(
        .DELAY_TICKS (DELAY_TICKS),
        .ACCEL_TICKS (ACCEL_TICKS)
`ifdef GUN_MOUSE_EN
        ,
        .MOUSE_SHIFT (MOUSE_SHIFT)
`endif
    ) u_axis_h (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .rise         (rise),
        .neg          (joy_left),
        .pos_in       (joy_right),
`ifdef GUN_MOUSE_EN
        .mouse_strobe (mouse_strobe),
        .delta        (delta_h),
`endif
        .pos          (gun_h),
        .busy_c       (busy_h_c)
    );

    gun_axis #(
        .DELAY_TICKS (DELAY_TICKS),
        .ACCEL_TICKS (ACCEL_TICKS)
`ifdef GUN_MOUSE_EN
        ,
        .MOUSE_SHIFT (MOUSE_SHIFT)
`endif
    ) u_axis_v (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .rise         (rise),
        .neg          (joy_up),
        .pos_in       (joy_down),
`ifdef GUN_MOUSE_EN
        .mouse_strobe (mouse_strobe),
        .delta        (delta_v),
`endif
        .pos          (gun_v),
        .busy_c       (busy_v_c)
    );

    // Registered in step with the axis state registers.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            moving <= 1'b0;
        end else begin
            moving <= busy_h_c | busy_v_c;
        end
    end

endmodule

// File: tb/tb_gun_position.sv
// Randomised self-checking bench for gun_position against a hold-count model.
// Mouse scenarios are compiled only with GUN_MOUSE_EN.
module tb_gun_position;

    localparam int DT = 8;
    localparam int AT = 16;
    localparam int MS = 2;

    logic clk_sys = 1'b0;
    logic reset_n;
    logic tick;
    logic joy_left, joy_right, joy_up, joy_down;
    logic [5:0] gun_h, gun_v;
    logic moving;
`ifdef GUN_MOUSE_EN
    logic mouse_strobe;
    logic signed [8:0] mouse_dx, mouse_dy;
`endif

    always #5 clk_sys = ~clk_sys;

    gun_position #(
        .DELAY_TICKS (DT),
        .ACCEL_TICKS (AT),
        .MOUSE_SHIFT (MS)
    ) dut (
        .clk_sys      (clk_sys),
        .reset_n      (reset_n),
        .tick         (tick),
        .joy_left     (joy_left),
        .joy_right    (joy_right),
        .joy_up       (joy_up),
        .joy_down     (joy_down),
`ifdef GUN_MOUSE_EN
        .mouse_strobe (mouse_strobe),
        .mouse_dx     (mouse_dx),
        .mouse_dy     (mouse_dy),
`endif
        .gun_h        (gun_h),
        .gun_v        (gun_v),
        .moving       (moving)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Model state per axis (0 = h, 1 = v): ticks held in one direction, that
    // direction, mouse remainder and position.
    int held [2];
    int hdir [2];
    int macc [2];
    int mpos [2];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Step for one tick given how long the direction has been held.
    function automatic int joy_model(input int ax, input int d);
        if (d == 0) begin
            held[ax] = 0;
            return 0;
        end
        if (held[ax] == 0 || d != hdir[ax]) begin
            held[ax] = 1;
            hdir[ax] = d;
            return d;
        end
        if (held[ax] < 100000) held[ax]++;
        if (held[ax] <= DT + 1) return 0;
        return (held[ax] - DT - 1 <= AT) ? d : 2 * d;
    endfunction

    function automatic int mouse_model(input int ax, input int delta);
        int s;
        macc[ax] += delta;
        s = macc[ax] / (1 << MS);
        macc[ax] -= s * (1 << MS);
        return s;
    endfunction

    function automatic int clampi(input int v);
        return (v < 0) ? 0 : ((v > 63) ? 63 : v);
    endfunction

    task automatic model_reset();
        for (int a = 0; a < 2; a++) begin
            held[a] = 0;
            hdir[a] = 0;
            macc[a] = 0;
            mpos[a] = 32;
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_h"}, 32'(gun_h), 32'(mpos[0]));
        check({tag, "_v"}, 32'(gun_v), 32'(mpos[1]));
        check({tag, "_moving"}, 32'(moving), 32'(held[0] != 0 || held[1] != 0));
    endtask

    task automatic set_joy(input logic l, input logic r, input logic u, input logic d);
        joy_left  = l;
        joy_right = r;
        joy_up    = u;
        joy_down  = d;
    endtask

    // One tick rise and/or mouse strobe, then model update and checks.
    task automatic run_event(input string tag, input bit t, input bit m,
                             input int dx, input int dy);
        int dh, dv, jh, jv, mh, mv;
        @(negedge clk_sys);
        tick = t;
`ifdef GUN_MOUSE_EN
        mouse_strobe = m;
        mouse_dx     = 9'(dx);
        mouse_dy     = 9'(dy);
`endif
        @(negedge clk_sys);
`ifdef GUN_MOUSE_EN
        mouse_strobe = 1'b0;
`endif
        @(negedge clk_sys);
        tick = 1'b0;
        @(negedge clk_sys);
        dh = int'(joy_right) - int'(joy_left);
        dv = int'(joy_down) - int'(joy_up);
        jh = t ? joy_model(0, dh) : 0;
        jv = t ? joy_model(1, dv) : 0;
        mh = m ? mouse_model(0, dx) : 0;
        mv = m ? mouse_model(1, -dy) : 0;
        mpos[0] = clampi(mpos[0] + jh + mh);
        mpos[1] = clampi(mpos[1] + jv + mv);
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset_n = 1'b0;
        model_reset();
        @(negedge clk_sys);
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        tick    = 1'b0;
        set_joy(0, 0, 0, 0);
`ifdef GUN_MOUSE_EN
        mouse_strobe = 1'b0;
        mouse_dx     = '0;
        mouse_dy     = '0;
`endif
        model_reset();
        repeat (3) @(negedge clk_sys);
        check_all("reset");
        reset_n = 1'b1;

        // Idle: nothing moves.
        for (int i = 0; i < 20; i++) run_event("idle", 1, 0, 0, 0);

        // Hold right through delay, repeat and acceleration.
        set_joy(0, 1, 0, 0);
        for (int i = 0; i < 40; i++) run_event("right", 1, 0, 0, 0);

        // Hold left long enough to pin at the lower limit.
        set_joy(1, 0, 0, 0);
        for (int i = 0; i < 200; i++) run_event("left", 1, 0, 0, 0);
        check("left_floor", 32'(gun_h), 32'd0);

        set_joy(0, 0, 0, 0);
        run_event("release", 1, 0, 0, 0);
        set_joy(0, 1, 0, 0);
        run_event("repress", 1, 0, 0, 0);
        check("repress_from_floor", 32'(gun_h), 32'd1);

        // Opposing vertical buttons cancel.
        set_joy(0, 0, 1, 1);
        for (int i = 0; i < 10; i++) run_event("updown", 1, 0, 0, 0);
        check("updown_idle", 32'(moving), 32'd0);

        // Right into repeat, then reverse.
        set_joy(0, 1, 0, 0);
        for (int i = 0; i < 14; i++) run_event("pre_rev", 1, 0, 0, 0);
        set_joy(1, 0, 0, 0);
        for (int i = 0; i < 12; i++) run_event("reversal", 1, 0, 0, 0);

        // Reset mid-move takes effect without waiting for a clock edge.
        set_joy(0, 1, 0, 1);
        for (int i = 0; i < 3; i++) run_event("pre_rst", 1, 0, 0, 0);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_h", 32'(gun_h), 32'd32);
        check("async_rst_v", 32'(gun_v), 32'd32);
        check("async_rst_moving", 32'(moving), 32'd0);
        model_reset();
        set_joy(0, 0, 0, 0);
        @(negedge clk_sys);
        reset_n = 1'b1;

`ifdef GUN_MOUSE_EN
        // Mouse remainder handling.
        do_reset();
        run_event("mouse_p5", 0, 1, 5, 0);
        check("mouse_p5_const", 32'(gun_h), 32'd33);
        run_event("mouse_p3", 0, 1, 3, 0);
        check("mouse_p3_const", 32'(gun_h), 32'd34);
        do_reset();
        run_event("mouse_m256", 0, 1, -256, 0);
        check("mouse_m256_const", 32'(gun_h), 32'd0);

        // Joystick rise and mouse strobe together share one clamp.
        do_reset();
        run_event("mouse_to62", 0, 1, 120, 0);
        set_joy(0, 1, 0, 0);
        run_event("coincident", 1, 1, 8, 0);
        check("coincident_const", 32'(gun_h), 32'd63);

        // Reset asserted in the cycle of a coincident update wins.
        @(negedge clk_sys);
        tick         = 1'b1;
        mouse_strobe = 1'b1;
        mouse_dx     = 9'sd8;
        reset_n      = 1'b0;
        @(negedge clk_sys);
        mouse_strobe = 1'b0;
        tick         = 1'b0;
        check("coincident_rst_h", 32'(gun_h), 32'd32);
        model_reset();
        reset_n = 1'b1;
        set_joy(0, 0, 0, 0);
        @(negedge clk_sys);
`endif

        // Random holds, releases, reversals and (if built) mouse packets.
        for (int i = 0; i < 400; i++) begin
            bit t, m;
            int dx, dy;
            if ($urandom_range(0, 5) == 0) begin
                set_joy(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
`ifdef GUN_MOUSE_EN
            m = ($urandom_range(0, 3) == 0);
            t = ($urandom_range(0, 7) != 0);
`else
            m = 1'b0;
            t = 1'b1;
`endif
            dx = int'($urandom_range(0, 511)) - 256;
            dy = int'($urandom_range(0, 511)) - 256;
            run_event("random", t, m, dx, dy);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
